// File: rtl/ddr3_dfi_target_pkg.sv
// Shared DDR3 definitions: DFI command encodings, timing constants and error codes.
// The controller uses the same package, so both sides agree on encodings.
package ddr3_dfi_target_pkg;

  // {CS#, RAS#, CAS#, WE#}; only decoded when CS# is low
  typedef enum logic [3:0] {
    CMD_MODE = 4'b0000,
    CMD_REFR = 4'b0001,
    CMD_PREC = 4'b0010,
    CMD_ACTV = 4'b0011,
    CMD_WRIT = 4'b0100,
    CMD_READ = 4'b0101,
    CMD_ZQCL = 4'b0110,
    CMD_NOOP = 4'b0111
  } cmd_e;

  localparam int TACTIVATE  = 4;
  localparam int TPRECHARGE = 4;
  localparam int TREFRESH   = 16;
  localparam int TCCD       = 4;

  localparam int TMR_W = 5;

  localparam logic [3:0] ERR_ACT_OPEN  = 4'd1;
  localparam logic [3:0] ERR_RW_CLOSED = 4'd2;
  localparam logic [3:0] ERR_REF_OPEN  = 4'd3;
  localparam logic [3:0] ERR_TRCD      = 4'd4;
  localparam logic [3:0] ERR_TRP       = 4'd5;
  localparam logic [3:0] ERR_TRFC      = 4'd6;
  localparam logic [3:0] ERR_TCCD      = 4'd7;
  localparam logic [3:0] ERR_WREN      = 4'd8;

  // A timer loaded in the command cycle reaches zero exactly 'cycles' later
  function automatic logic [TMR_W-1:0] tmr_load(input int cycles);
    return TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/ddr3_model_ram.sv
// Backing store for the DDR3 target: 1W/1R synchronous RAM with byte enables.
// Read data is registered; a same-cycle read and write of one word returns the old data.
module ddr3_model_ram #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    wr_en,
  input  logic [ADDR_BITS-1:0]    wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_BITS-1:0]    rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++)
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/ddr3_dfi_target.sv
// Behavioural DDR3 device on the DFI bus: bank/timing tracking with sticky error
// reporting, and pipelined 4-beat bursts served from ddr3_model_ram.
module ddr3_dfi_target
  import ddr3_dfi_target_pkg::*;
#(
  parameter int DDR_WR_LATENCY = 6,
  parameter int DDR_RD_LATENCY = 5,
  parameter int DDR_COL_BITS   = 9,
  parameter int DDR_ROW_BITS   = 15,
  parameter int DDR_DATA_WIDTH = 32,
  parameter int MEM_ADDR_BITS  = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        dfi_cke_i,
  input  logic                        dfi_reset_n_i,
  input  logic                        dfi_cs_n_i,
  input  logic                        dfi_ras_n_i,
  input  logic                        dfi_cas_n_i,
  input  logic                        dfi_we_n_i,
  input  logic [2:0]                  dfi_bank_i,
  input  logic [DDR_ROW_BITS-1:0]     dfi_addr_i,
  input  logic                        dfi_wren_i,
  input  logic [DDR_DATA_WIDTH/8-1:0] dfi_mask_i,
  input  logic [DDR_DATA_WIDTH-1:0]   dfi_data_i,
  output logic                        dfi_valid_o,
  output logic [DDR_DATA_WIDTH-1:0]   dfi_data_o,
  output logic [1:0]                  dfi_rddata_dnv_o,
  output logic                        err_o,
  output logic [3:0]                  err_code_o,
  output logic                        busy_o
);

  // Stage s of the pipe holds the READ/WRIT issued s cycles ago
  localparam int STAGES = (DDR_RD_LATENCY + 2 > DDR_WR_LATENCY + 3) ?
                          DDR_RD_LATENCY + 2 : DDR_WR_LATENCY + 3;
  localparam int WORD_W = MEM_ADDR_BITS - 2;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic              ap;
    logic [2:0]        bank;
    logic [WORD_W-1:0] word;
  } burst_t;

  logic [7:0]                         bank_open, close_mask;
  logic [7:0][DDR_ROW_BITS-1:0]       bank_row;
  logic [7:0][TMR_W-1:0]              act_tmr, pre_tmr;
  logic [TMR_W-1:0]                   ref_tmr, ccd_tmr;
  burst_t                             pipe [STAGES:1];
  burst_t                             new_burst;
  cmd_e                               cmd;
  logic [8:1]                         err_flags;
  logic [3:0]                         err_code_now;
  logic                               cmd_ok, wr_win, rd_issue, pipe_busy, valid_q;
  logic [MEM_ADDR_BITS-1:0]           wr_addr, rd_addr;
  logic [DDR_DATA_WIDTH-1:0]          ram_q;

  assign cmd = (dfi_cke_i && dfi_reset_n_i && !dfi_cs_n_i) ?
               cmd_e'({dfi_cs_n_i, dfi_ras_n_i, dfi_cas_n_i, dfi_we_n_i}) : CMD_NOOP;

  always_comb begin
    err_flags = '0;
    case (cmd)
      CMD_ACTV: begin
        err_flags[ERR_ACT_OPEN] = bank_open[dfi_bank_i];
        err_flags[ERR_TRP]      = pre_tmr[dfi_bank_i] != '0;
        err_flags[ERR_TRFC]     = ref_tmr != '0;
      end
      CMD_READ, CMD_WRIT: begin
        err_flags[ERR_RW_CLOSED] = !bank_open[dfi_bank_i];
        err_flags[ERR_TRCD]      = act_tmr[dfi_bank_i] != '0;
        err_flags[ERR_TRFC]      = ref_tmr != '0;
        err_flags[ERR_TCCD]      = ccd_tmr != '0;
      end
      CMD_REFR: begin
        err_flags[ERR_REF_OPEN] = |bank_open;
        err_flags[ERR_TRFC]     = ref_tmr != '0;
      end
      CMD_PREC, CMD_MODE, CMD_ZQCL: err_flags[ERR_TRFC] = ref_tmr != '0;
      default: ;
    endcase
    err_flags[ERR_WREN] = dfi_wren_i != wr_win;
  end

  // A command that violates protocol is reported and then dropped
  assign cmd_ok = ~|err_flags[7:1];

  always_comb begin
    err_code_now = '0;
    for (int c = 8; c >= 1; c--)
      if (err_flags[c]) err_code_now = 4'(c);
  end

  always_comb begin
    new_burst      = '0;
    new_burst.rd   = cmd_ok && (cmd == CMD_READ);
    new_burst.wr   = cmd_ok && (cmd == CMD_WRIT);
    new_burst.ap   = dfi_addr_i[10];
    new_burst.bank = dfi_bank_i;
    new_burst.word = WORD_W'({dfi_bank_i, bank_row[dfi_bank_i],
                              dfi_addr_i[DDR_COL_BITS-1:2]});
  end

  // tCCD keeps at most one burst inside each beat window
  always_comb begin
    wr_win     = 1'b0;
    wr_addr    = '0;
    rd_issue   = 1'b0;
    rd_addr    = '0;
    close_mask = '0;
    pipe_busy  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (pipe[DDR_WR_LATENCY+k].wr) begin
        wr_win  = 1'b1;
        wr_addr = {pipe[DDR_WR_LATENCY+k].word, 2'(k)};
      end
      if (pipe[DDR_RD_LATENCY-1+k].rd) begin
        rd_issue = 1'b1;
        rd_addr  = {pipe[DDR_RD_LATENCY-1+k].word, 2'(k)};
      end
    end
    if (pipe[DDR_RD_LATENCY+2].rd && pipe[DDR_RD_LATENCY+2].ap)
      close_mask[pipe[DDR_RD_LATENCY+2].bank] = 1'b1;
    if (pipe[DDR_WR_LATENCY+3].wr && pipe[DDR_WR_LATENCY+3].ap)
      close_mask[pipe[DDR_WR_LATENCY+3].bank] = 1'b1;
    for (int s = 1; s <= STAGES; s++)
      pipe_busy = pipe_busy | pipe[s].rd | pipe[s].wr;
  end

  always_ff @(posedge clock) begin
    if (reset || !dfi_reset_n_i) begin
      bank_open <= '0;
      act_tmr   <= '0;
      pre_tmr   <= '0;
      ref_tmr   <= '0;
      ccd_tmr   <= '0;
      for (int s = 1; s <= STAGES; s++) pipe[s] <= '0;
    end else begin
      for (int b = 0; b < 8; b++) begin
        if (act_tmr[b] != '0) act_tmr[b] <= act_tmr[b] - 1'b1;
        if (pre_tmr[b] != '0) pre_tmr[b] <= pre_tmr[b] - 1'b1;
      end
      if (ref_tmr != '0) ref_tmr <= ref_tmr - 1'b1;
      if (ccd_tmr != '0) ccd_tmr <= ccd_tmr - 1'b1;
      for (int s = STAGES; s > 1; s--) pipe[s] <= pipe[s-1];
      pipe[1]   <= new_burst;
      bank_open <= bank_open & ~close_mask;
      if (cmd_ok) begin
        case (cmd)
          CMD_ACTV: begin
            bank_open[dfi_bank_i] <= 1'b1;
            bank_row[dfi_bank_i]  <= dfi_addr_i;
            act_tmr[dfi_bank_i]   <= tmr_load(TACTIVATE);
          end
          CMD_PREC: begin
            if (dfi_addr_i[10]) begin
              bank_open <= '0;
              for (int b = 0; b < 8; b++) pre_tmr[b] <= tmr_load(TPRECHARGE);
            end else begin
              bank_open[dfi_bank_i] <= 1'b0;
              pre_tmr[dfi_bank_i]   <= tmr_load(TPRECHARGE);
            end
          end
          CMD_READ, CMD_WRIT: ccd_tmr <= tmr_load(TCCD);
          CMD_REFR:           ref_tmr <= tmr_load(TREFRESH);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !dfi_reset_n_i) valid_q <= 1'b0;
    else                         valid_q <= rd_issue;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_o      <= 1'b0;
      err_code_o <= '0;
    end else if (!err_o && err_code_now != '0) begin
      err_o      <= 1'b1;
      err_code_o <= err_code_now;
    end
  end

  ddr3_model_ram #(
    .ADDR_BITS  (MEM_ADDR_BITS),
    .DATA_WIDTH (DDR_DATA_WIDTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_win && dfi_wren_i && dfi_reset_n_i && !reset),
    .wr_addr (wr_addr),
    .wr_be   (~dfi_mask_i),
    .wr_data (dfi_data_i),
    .rd_en   (rd_issue),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  assign dfi_valid_o      = valid_q;
  assign dfi_data_o       = valid_q ? ram_q : '0;
  assign dfi_rddata_dnv_o = 2'b00;
  assign busy_o = valid_q | pipe_busy | (|act_tmr) | (|pre_tmr) |
                  (ref_tmr != '0) | (ccd_tmr != '0);

endmodule

// File: tb/tb_ddr3_dfi_target.sv
// Directed bench for ddr3_dfi_target: table of write/read bursts plus
// hand-built sequences for pipelining, protocol errors and mid-burst reset.
module tb_ddr3_dfi_target;

  localparam logic [3:0] C_NOOP = 4'b0111, C_ACTV = 4'b0011, C_READ = 4'b0101,
                         C_WRIT = 4'b0100, C_REFR = 4'b0001;

  logic        clock = 1'b0;
  logic        reset;
  logic        cke, reset_n, cs_n, ras_n, cas_n, we_n;
  logic [2:0]  bank;
  logic [14:0] addr;
  logic        wren;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        valid;
  logic [31:0] rdata;
  logic [1:0]  dnv;
  logic        err;
  logic [3:0]  err_code;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0]       bank;
    logic [14:0]      row;
    logic [14:0]      col;
    logic [3:0][31:0] data;
    logic [3:0][3:0]  mask;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t vecs [4];

  ddr3_dfi_target dut (
    .clock            (clock),
    .reset            (reset),
    .dfi_cke_i        (cke),
    .dfi_reset_n_i    (reset_n),
    .dfi_cs_n_i       (cs_n),
    .dfi_ras_n_i      (ras_n),
    .dfi_cas_n_i      (cas_n),
    .dfi_we_n_i       (we_n),
    .dfi_bank_i       (bank),
    .dfi_addr_i       (addr),
    .dfi_wren_i       (wren),
    .dfi_mask_i       (mask),
    .dfi_data_i       (wdata),
    .dfi_valid_o      (valid),
    .dfi_data_o       (rdata),
    .dfi_rddata_dnv_o (dnv),
    .err_o            (err),
    .err_code_o       (err_code),
    .busy_o           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic idle();
    {cs_n, ras_n, cas_n, we_n} = C_NOOP;
    bank = '0; addr = '0; wren = 1'b0; mask = '0; wdata = '0;
  endtask

  task automatic issue(input logic [3:0] c, input logic [2:0] b, input logic [14:0] a);
    {cs_n, ras_n, cas_n, we_n} = c;
    bank = b;
    addr = a;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    repeat (3) tick();
    reset = 1'b0;
  endtask

  initial begin
    int nb;
    vec_t v;
    vecs[0] = '{bank: 3'd2, row: 15'h0012, col: 15'h008,
                data: {32'hA3, 32'hA2, 32'hA1, 32'hA0}, mask: 16'h0000,
                exp:  {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
    vecs[1] = '{bank: 3'd1, row: 15'h0005, col: 15'h010,
                data: {4{32'hFFFF_FFFF}}, mask: 16'h0000,
                exp:  {4{32'hFFFF_FFFF}}};
    vecs[2] = '{bank: 3'd1, row: 15'h0005, col: 15'h011,
                data: {32'h55AA_55AA, 32'h0000_0000, 32'h1234_5678, 32'hDEAD_0000},
                mask: 16'h5F30,
                exp:  {32'h55FF_55FF, 32'hFFFF_FFFF, 32'h1234_FFFF, 32'hDEAD_0000}};
    vecs[3] = '{bank: 3'd7, row: 15'h7FFF, col: 15'h1FF,
                data: {32'h0BAD_F00D, 32'hCAFE_BABE, 32'h1357_9BDF, 32'h8000_0001},
                mask: 16'h0000,
                exp:  {32'h0BAD_F00D, 32'hCAFE_BABE, 32'h1357_9BDF, 32'h8000_0001}};

    cke = 1'b1;
    reset_n = 1'b1;
    do_reset();
    check("rst_valid", valid, 0);
    check("rst_data", rdata, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_busy", busy, 0);
    check("rst_dnv", dnv, 0);

    // ACTV@0, WRIT@4 (beats 10..13), READ with auto-precharge @8 (beats 13..16)
    for (int r = 0; r < 4; r++) begin
      v = vecs[r];
      nb = 0;
      for (int i = 0; i < 24; i++) begin
        idle();
        if (i == 0) issue(C_ACTV, v.bank, v.row);
        if (i == 4) issue(C_WRIT, v.bank, v.col);
        if (i == 8) issue(C_READ, v.bank, v.col | 15'h400);
        if (i >= 10 && i <= 13) begin
          wren  = 1'b1;
          mask  = v.mask[i-10];
          wdata = v.data[i-10];
        end
        if (valid) begin
          check("vec_beat_cycle", i, 13 + nb);
          if (nb < 4) check("vec_data", rdata, v.exp[nb]);
          nb++;
        end else begin
          check("vec_idle_data", rdata, 0);
        end
        tick();
      end
      check("vec_beats", nb, 4);
    end
    check("vec_no_err", err, 0);

    // Two READs 4 cycles apart: 8 back-to-back beats
    for (int i = 0; i < 20; i++) begin
      idle();
      if (i == 0) issue(C_ACTV, 3'd2, 15'h0012);
      if (i == 4 || i == 8) issue(C_READ, 3'd2, 15'h008);
      if (i >= 9 && i <= 16) begin
        check("pipe_valid", valid, 1);
        check("pipe_data", rdata, 32'hA0 + ((i - 9) % 4));
      end else if (i == 8 || i == 17) begin
        check("pipe_edge", valid, 0);
      end
      tick();
    end
    check("pipe_no_err", err, 0);

    // READ on closed bank 3
    do_reset();
    nb = 0;
    for (int i = 0; i < 14; i++) begin
      idle();
      if (i == 0) issue(C_READ, 3'd3, 15'h000);
      if (valid) nb++;
      tick();
    end
    check("closed_err", err, 1);
    check("closed_code", err_code, 2);
    check("closed_beats", nb, 0);

    // READs 3 cycles apart
    do_reset();
    for (int i = 0; i < 12; i++) begin
      idle();
      if (i == 0) issue(C_ACTV, 3'd0, 15'h0000);
      if (i == 4 || i == 7) issue(C_READ, 3'd0, 15'h000);
      tick();
    end
    check("tccd_code", err_code, 7);

    // ACTV->READ after 2, then REFR with bank open: first code kept
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i == 0) issue(C_ACTV, 3'd0, 15'h0000);
      if (i == 2) issue(C_READ, 3'd0, 15'h000);
      if (i == 8) issue(C_REFR, 3'd0, 15'h000);
      if (i == 5) check("trcd_code", err_code, 4);
      tick();
    end
    check("first_code_kept", err_code, 4);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i == 0) issue(C_ACTV, 3'd0, 15'h0000);
      if (i == 5) issue(C_REFR, 3'd0, 15'h000);
      tick();
    end
    check("refr_open_code", err_code, 3);

    // Stray wren with no write window
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i == 1) wren = 1'b1;
      tick();
    end
    check("wren_err", err, 1);
    check("wren_code", err_code, 8);

    // Reset during beat 2 of the second of two writes to the same words
    do_reset();
    for (int i = 0; i < 17; i++) begin
      idle();
      if (i == 0) issue(C_ACTV, 3'd1, 15'h0020);
      if (i == 4 || i == 8) issue(C_WRIT, 3'd1, 15'h000);
      if (i >= 10 && i <= 13) begin wren = 1'b1; wdata = 32'h1111_0000 + (i - 10); end
      if (i >= 14) begin wren = 1'b1; wdata = 32'h2222_0000 + (i - 14); end
      if (i == 16) reset = 1'b1;
      tick();
    end
    idle();
    tick();
    reset = 1'b0;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_busy", busy, 0);
    nb = 0;
    for (int i = 0; i < 16; i++) begin
      idle();
      if (i == 0) issue(C_ACTV, 3'd1, 15'h0020);
      if (i == 4) issue(C_READ, 3'd1, 15'h400);
      if (valid) begin
        case (nb)
          0: check("mid_rst_b0", rdata, 32'h2222_0000);
          1: check("mid_rst_b1", rdata, 32'h2222_0001);
          2: check("mid_rst_b2", rdata, 32'h1111_0002);
          default: check("mid_rst_b3", rdata, 32'h1111_0003);
        endcase
        nb++;
      end
      tick();
    end
    check("mid_rst_beats", nb, 4);
    check("mid_rst_banks_closed", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
